ex_muldiv: RTL

Iterative RV32M multiply/divide unit in the EX stage of the five-stage RV32 pipeline. It consumes the instruction and forwarded operands captured by the ID/EX pipeline register. It raises a stall that freezes PC, IF/ID and ID/EX while it iterates, then presents a 32-bit result to the EX/MEM write-back path for exactly one cycle.

---
 rtl/ex_muldiv.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide for EX, 32 cycles per op.
// clk/rst_n; ex_inst/ex_a/ex_b in; stall_o, result_o, result_valid_o out.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ex_inst,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_b,
  output logic        stall_o,
  output logic [31:0] result_o,
  output logic        result_valid_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        neg_q, neg_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] res_q, res_d;
  logic        vld_q, vld_d;
  logic        stall_d;

  logic        is_m, is_div;
  logic [2:0]  f3;
  logic        sgn_a, sgn_b, sa, sb;
  logic [31:0] abs_a, abs_b;
  logic        neg_st, div0, ovf;
  logic [31:0] fast_res;

  assign is_m = (ex_inst[6:0] == 7'b0110011)
             && (ex_inst[31:25] == 7'b0000001);
  assign f3     = ex_inst[14:12];
  assign is_div = f3[2];
  assign sgn_a  = is_div ? ~f3[0] : (f3[1:0] != 2'b11);
  assign sgn_b  = is_div ? ~f3[0] : ~f3[1];
  assign sa     = sgn_a & ex_a[31];
  assign sb     = sgn_b & ex_b[31];
  assign abs_a  = sa ? (32'd0 - ex_a) : ex_a;
  assign abs_b  = sb ? (32'd0 - ex_b) : ex_b;
  // remainder follows the dividend only
  assign neg_st = (is_div & f3[1]) ? sa : (sa ^ sb);
  assign div0   = is_div & (ex_b == 32'd0);
  assign ovf    = is_div & ~f3[0]
               & (ex_a == 32'h8000_0000)
               & (ex_b == 32'hFFFF_FFFF);
  assign fast_res = div0 ? (f3[1] ? ex_a : 32'hFFFF_FFFF)
                         : (f3[1] ? 32'd0 : 32'h8000_0000);

  // mul: acc = {partial hi, multiplier shifting out}
  logic [32:0] mul_sum;
  logic [63:0] mul_nxt;
  assign mul_sum = {1'b0, acc_q[63:32]}
                 + (acc_q[0] ? {1'b0, a_q} : 33'd0);
  assign mul_nxt = {mul_sum, acc_q[31:1]};

  // div: acc = {remainder, dividend/quotient}
  logic [32:0] div_tmp;
  logic [33:0] div_dif;
  logic        div_ok;
  logic [63:0] div_nxt;
  assign div_tmp = acc_q[63:31];
  assign div_dif = {1'b0, div_tmp} - {2'b00, b_q};
  assign div_ok  = ~div_dif[33];
  assign div_nxt = {div_ok ? div_dif[31:0] : div_tmp[31:0],
                    acc_q[30:0], div_ok};

  logic [63:0] step, prod;
  logic [31:0] sq, sr, fin;
  assign step = f3_q[2] ? div_nxt : mul_nxt;
  assign prod = neg_q ? (64'd0 - step) : step;
  assign sq   = neg_q ? (32'd0 - step[31:0]) : step[31:0];
  assign sr   = neg_q ? (32'd0 - step[63:32]) : step[63:32];

  always_comb begin
    fin = prod[31:0];
    unique case (1'b1)
      (f3_q == 3'd0):           fin = prod[31:0];
      (~f3_q[2] & |f3_q[1:0]):  fin = prod[63:32];
      (f3_q[2] & ~f3_q[1]):     fin = sq;
      (f3_q[2] & f3_q[1]):      fin = sr;
      default:                  fin = prod[31:0];
    endcase
  end

  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    a_d     = a_q;
    b_d     = b_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    vld_d   = 1'b0;
    stall_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (is_m) begin
          stall_d = 1'b1;
          f3_d    = f3;
          a_d     = abs_a;
          b_d     = abs_b;
          neg_d   = neg_st;
          cnt_d   = 5'd0;
          acc_d   = is_div ? {32'd0, abs_a}
                           : {32'd0, abs_b};
          if (div0 | ovf) begin
            state_d = DONE;
            res_d   = fast_res;
            vld_d   = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall_d = 1'b1;
        acc_d   = step;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DONE;
          res_d   = fin;
          vld_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // keep stall low while reset holds, even with M in EX
  assign stall_o        = stall_d & rst_n;
  assign result_o       = res_q;
  assign result_valid_o = vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      f3_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      neg_q   <= 1'b0;
      cnt_q   <= 5'd0;
      acc_q   <= 64'd0;
      res_q   <= 32'd0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      vld_q   <= vld_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ex_inst[24:15], ex_inst[11:7],
                         div_dif[32]};

endmodule
